multicycle_controller: RTL and testbench

Parametrised successor to the single-cycle AND/ADDI controller. It decodes the full RV32I integer subset: R/I ALU ops, LUI, loads, stores, conditional branches, JAL/JALR and CSRR/return. It sequences memory accesses through a busy handshake and adds a vectored interrupt with saved return PC. It sits between the instruction memory, the register-file/ALU datapath and the data memory/cache, and owns the program counter.

---
 rtl/multicycle_controller_if.sv | 43 ++++
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Controller <-> instruction memory, datapath and data memory bundle.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if #(
    parameter int NBITS       = 8,
    parameter int NREGS       = 32,
    parameter int WIDTH_ALUF  = 4,
    parameter int NINSTR_BITS = 32
);
    localparam int RW = $clog2(NREGS);

    logic [NINSTR_BITS-1:0] instruction;
    logic [NBITS-1:0]       pc;
    logic [RW-1:0]          RS1;
    logic [RW-1:0]          RS2;
    logic [RW-1:0]          RD;
    logic signed [NBITS-1:0] IMM;
    logic                   ALUSrc;
    logic                   MemtoReg;
    logic                   RegWrite;
    logic                   link;
    logic [WIDTH_ALUF-1:0]  ALUControl;
    logic [NBITS-1:0]       pclink;
    logic                   Zero;
    logic                   Neg;
    logic                   Carry;
    logic [NBITS-1:0]       PCReg;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   busy;
    logic                   interrupt;

    modport master (
        input  instruction, Zero, Neg, Carry, PCReg, busy, interrupt,
        output pc, RS1, RS2, RD, IMM, ALUSrc, MemtoReg, RegWrite, link,
        output ALUControl, pclink, MemRead, MemWrite
    );

    modport slave (
        output instruction, Zero, Neg, Carry, PCReg, busy, interrupt,
        input  pc, RS1, RS2, RD, IMM, ALUSrc, MemtoReg, RegWrite, link,
        input  ALUControl, pclink, MemRead, MemWrite
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: decode, PC sequencing, busy-gated memory access.
// Vectored interrupt with saved return PC is enabled by CTRL_INTERRUPT_EN.
module multicycle_controller #(
    parameter int NBITS       = 8,
    parameter int NREGS       = 32,
    parameter int WIDTH_ALUF  = 4,
    parameter int NINSTR_BITS = 32,
    parameter logic [NBITS-1:0] TRAP_VEC = 'h10
) (
    input logic clock,
    input logic reset,
    multicycle_controller_if.master bus
);
    localparam int RW = $clog2(NREGS);
    localparam logic [NBITS-1:0] FOUR = NBITS'(4);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_OPIMM = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_OP    = 5'b01100;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_SYS   = 5'b11100;

    localparam logic [WIDTH_ALUF-1:0] ALU_ADD = '0;
    localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);

    typedef enum logic {EXEC, MEM} state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] sepc_q, sepc_d;
    logic             ie_q, ie_d;

    logic [31:0] instr;
    logic [4:0]  opc;
    logic [2:0]  f3;

    assign instr = bus.instruction[31:0];
    assign opc   = instr[6:2];
    assign f3    = instr[14:12];

    logic is_load, is_opimm, is_store, is_op, is_lui;
    logic is_br, is_jalr, is_jal, is_ret, is_csrr;

    assign is_load  = (opc == OP_LOAD);
    assign is_opimm = (opc == OP_OPIMM);
    assign is_store = (opc == OP_STORE);
    assign is_op    = (opc == OP_OP);
    assign is_lui   = (opc == OP_LUI);
    assign is_br    = (opc == OP_BR);
    assign is_jalr  = (opc == OP_JALR);
    assign is_jal   = (opc == OP_JAL);
    assign is_ret   = (opc == OP_SYS) && (f3 == 3'b000)
                   && (instr[31:20] == 12'h302);
    assign is_csrr  = (opc == OP_SYS) && (f3 != 3'b000);

    logic [31:0]      imm32;
    logic [NBITS-1:0] imm_n;

    always_comb begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        unique case (1'b1)
            is_store: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_br:    imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            is_lui:   imm32 = {instr[31:12], 12'b0};
            is_jal:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            default:  ;
        endcase
    end

    assign imm_n = NBITS'($signed(imm32));

    logic taken;

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            3'b000:  taken = bus.Zero;
            3'b001:  taken = ~bus.Zero;
            3'b100:  taken = bus.Neg;
            3'b101:  taken = ~bus.Neg;
            3'b110:  taken = bus.Carry;
            3'b111:  taken = ~bus.Carry;
            default: taken = 1'b0;
        endcase
    end

    logic [NBITS-1:0] jalr_sum;
    assign jalr_sum = bus.PCReg + imm_n;

    logic                  alusrc, regwr, memtoreg, lnk, memrd, memwr;
    logic                  rs1_zero, commit;
    logic [WIDTH_ALUF-1:0] aluf;
    logic [NBITS-1:0]      pclink, npc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sepc_d   = sepc_q;
        ie_d     = ie_q;
        alusrc   = 1'b0;
        aluf     = ALU_ADD;
        regwr    = 1'b0;
        memtoreg = 1'b0;
        lnk      = 1'b0;
        pclink   = '0;
        memrd    = 1'b0;
        memwr    = 1'b0;
        rs1_zero = 1'b0;
        commit   = 1'b0;
        npc      = pc_q + FOUR;
        if (state_q == MEM) begin
            // instruction stays at pc, so address operands remain stable
            alusrc = 1'b1;
            memrd  = is_load;
            memwr  = is_store;
            if (!bus.busy) begin
                regwr    = is_load;
                memtoreg = is_load;
                commit   = 1'b1;
                state_d  = EXEC;
            end
        end else begin
            unique case (1'b1)
                is_op: begin
                    aluf   = WIDTH_ALUF'({instr[30], f3});
                    regwr  = 1'b1;
                    commit = 1'b1;
                end
                is_opimm: begin
                    alusrc = 1'b1;
                    aluf   = WIDTH_ALUF'({(f3 == 3'b101) & instr[30], f3});
                    regwr  = 1'b1;
                    commit = 1'b1;
                end
                is_lui: begin
                    alusrc   = 1'b1;
                    rs1_zero = 1'b1;
                    regwr    = 1'b1;
                    commit   = 1'b1;
                end
                is_load, is_store: begin
                    alusrc  = 1'b1;
                    state_d = MEM;
                end
                is_br: begin
                    aluf   = ALU_SUB;
                    commit = 1'b1;
                    if (taken) npc = pc_q + imm_n;
                end
                is_jal: begin
                    lnk    = 1'b1;
                    pclink = pc_q + FOUR;
                    regwr  = 1'b1;
                    commit = 1'b1;
                    npc    = pc_q + imm_n;
                end
                is_jalr: begin
                    lnk    = 1'b1;
                    pclink = pc_q + FOUR;
                    regwr  = 1'b1;
                    commit = 1'b1;
                    npc    = {jalr_sum[NBITS-1:1], 1'b0};
                end
                is_ret: begin
                    commit = 1'b1;
                    npc    = sepc_q;
                end
                is_csrr: begin
                    lnk    = 1'b1;
                    pclink = sepc_q;
                    regwr  = 1'b1;
                    commit = 1'b1;
                end
                default: commit = 1'b1;
            endcase
        end
        if (commit) begin
            pc_d = npc;
`ifdef CTRL_INTERRUPT_EN
            // a return re-enables first; a pending request waits one commit
            if (is_ret) begin
                ie_d = 1'b1;
            end else if (bus.interrupt && ie_q) begin
                sepc_d = npc;
                pc_d   = TRAP_VEC;
                ie_d   = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EXEC;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef CTRL_INTERRUPT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sepc_q <= '0;
            ie_q   <= 1'b1;
        end else begin
            sepc_q <= sepc_d;
            ie_q   <= ie_d;
        end
    end
`else
    assign sepc_q = '0;
    assign ie_q   = 1'b0;

    logic unused_irq;
    assign unused_irq = ^{bus.interrupt, sepc_d, ie_d, ie_q};
`endif

    logic unused_instr;
    assign unused_instr = ^instr[1:0];

    assign bus.pc         = pc_q;
    assign bus.RS1        = rs1_zero ? '0 : RW'(instr[19:15]);
    assign bus.RS2        = RW'(instr[24:20]);
    assign bus.RD         = RW'(instr[11:7]);
    assign bus.IMM        = imm_n;
    assign bus.ALUSrc     = alusrc;
    assign bus.ALUControl = aluf;
    assign bus.pclink     = pclink;
    assign bus.MemtoReg   = memtoreg & ~reset;
    assign bus.RegWrite   = regwr & ~reset;
    assign bus.link       = lnk & ~reset;
    assign bus.MemRead    = memrd & ~reset;
    assign bus.MemWrite   = memwr & ~reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: decode, memory handshake,
// branches, jumps, wrap, interrupt entry/return and reset abort.
module tb_multicycle_controller;
  localparam int NBITS = 8;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_AND   = 32'h0010F133;
  localparam logic [31:0] I_SRAI  = 32'h4020D193;
  localparam logic [31:0] I_SUB   = 32'h40208233;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_UNK   = 32'h0000007F;
  localparam logic [31:0] I_LW    = 32'h0040A183;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3;
  localparam logic [31:0] I_BLTU  = 32'h0020E463;
  localparam logic [31:0] I_BGE   = 32'h0020D463;
  localparam logic [31:0] I_JAL   = 32'h00C000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_CSRR  = 32'h141022F3;
  localparam logic [31:0] I_MRET  = 32'h30200073;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  multicycle_controller_if #(.NBITS(NBITS)) bus ();

  multicycle_controller #(.NBITS(NBITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic set_in(input logic [31:0] ins, input logic bsy);
    @(negedge clock);
    bus.instruction = ins;
    bus.busy = bsy;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Zero = 0; bus.Neg = 0; bus.Carry = 0;
    bus.PCReg = '0; bus.interrupt = 0;
    set_in(I_ADDI, 1'b0);
    tick();
    set_in(I_ADDI, 1'b0);
    tests++;
    if ({bus.RegWrite, bus.MemRead, bus.MemWrite, bus.link,
         bus.MemtoReg} !== 5'b0) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.RegWrite, bus.MemRead, bus.MemWrite,
                bus.link, bus.MemtoReg});
    end
    tick();
    tests++;
    if (bus.pc !== 8'h00) begin
      fails++;
      $display("FAIL reset_pc: got %0h expected 0", bus.pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    set_in(I_ADDI, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.ALUControl, bus.RegWrite} !== 6'b1_0000_1) begin
      fails++;
      $display("FAIL addi_ctrl: got %b expected 100001",
               {bus.ALUSrc, bus.ALUControl, bus.RegWrite});
    end
    tests++;
    if (bus.IMM !== 8'h05 || bus.RD !== 5'd1) begin
      fails++;
      $display("FAIL addi_imm_rd: got %0h/%0d expected 5/1",
               bus.IMM, bus.RD);
    end
    tick();
    tests++;
    if (bus.pc !== 8'h04) begin
      fails++;
      $display("FAIL addi_pc: got %0h expected 4", bus.pc);
    end
    set_in(I_AND, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.ALUControl, bus.RegWrite} !== 6'b0_0111_1) begin
      fails++;
      $display("FAIL and_ctrl: got %b expected 001111",
               {bus.ALUSrc, bus.ALUControl, bus.RegWrite});
    end
    tick();
    tests++;
    if (bus.pc !== 8'h08) begin
      fails++;
      $display("FAIL and_pc: got %0h expected 8", bus.pc);
    end
  endtask

  task automatic test_load();
    int nrd = 0;
    set_in(I_LW, 1'b1);
    tests++;
    if ({bus.MemRead, bus.RegWrite, bus.ALUSrc} !== 3'b001
        || bus.IMM !== 8'h04) begin
      fails++;
      $display("FAIL lw_exec: got %b imm %0h expected 001 imm 4",
               {bus.MemRead, bus.RegWrite, bus.ALUSrc}, bus.IMM);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      set_in(I_LW, c < 3);
      if (bus.MemRead === 1'b1) nrd++;
      tests++;
      if (c < 3 && {bus.RegWrite, bus.MemtoReg} !== 2'b00) begin
        fails++;
        $display("FAIL lw_wait_wb: got %b expected 00",
                 {bus.RegWrite, bus.MemtoReg});
      end else if (c == 3 && {bus.RegWrite, bus.MemtoReg} !== 2'b11) begin
        fails++;
        $display("FAIL lw_done_wb: got %b expected 11",
                 {bus.RegWrite, bus.MemtoReg});
      end
      tick();
      tests++;
      if (c < 3 && bus.pc !== 8'h08) begin
        fails++;
        $display("FAIL lw_wait_pc: got %0h expected 8", bus.pc);
      end else if (c == 3 && bus.pc !== 8'h0C) begin
        fails++;
        $display("FAIL lw_done_pc: got %0h expected c", bus.pc);
      end
    end
    tests++;
    if (nrd !== 4) begin
      fails++;
      $display("FAIL lw_memread_cycles: got %0d expected 4", nrd);
    end
  endtask

  task automatic test_branch();
    bus.Zero = 1'b1;
    set_in(I_BEQ, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.ALUControl, bus.RegWrite} !== 6'b0_1000_0
        || bus.IMM !== 8'hF8) begin
      fails++;
      $display("FAIL beq_ctrl: got %b imm %0h expected 010000 imm f8",
               {bus.ALUSrc, bus.ALUControl, bus.RegWrite}, bus.IMM);
    end
    tick();
    tests++;
    if (bus.pc !== 8'h04) begin
      fails++;
      $display("FAIL beq_pc: got %0h expected 4", bus.pc);
    end
    bus.Zero = 1'b0;
    bus.Carry = 1'b1;
    set_in(I_BLTU, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h0C) begin
      fails++;
      $display("FAIL bltu_taken_pc: got %0h expected c", bus.pc);
    end
    bus.Carry = 1'b0;
    set_in(I_BLTU, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h10) begin
      fails++;
      $display("FAIL bltu_not_pc: got %0h expected 10", bus.pc);
    end
    bus.Neg = 1'b1;
    set_in(I_BGE, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h14) begin
      fails++;
      $display("FAIL bge_not_pc: got %0h expected 14", bus.pc);
    end
    bus.Neg = 1'b0;
  endtask

  task automatic test_jump();
    set_in(I_JAL, 1'b0);
    tests++;
    if ({bus.link, bus.RegWrite} !== 2'b11 || bus.pclink !== 8'h18) begin
      fails++;
      $display("FAIL jal_link: got %b/%0h expected 11/18",
               {bus.link, bus.RegWrite}, bus.pclink);
    end
    tick();
    tests++;
    if (bus.pc !== 8'h20) begin
      fails++;
      $display("FAIL jal_pc: got %0h expected 20", bus.pc);
    end
    bus.PCReg = 8'h41;
    set_in(I_JALR, 1'b0);
    tests++;
    if (bus.link !== 1'b1 || bus.pclink !== 8'h24) begin
      fails++;
      $display("FAIL jalr_link: got %b/%0h expected 1/24",
               bus.link, bus.pclink);
    end
    tick();
    tests++;
    if (bus.pc !== 8'h40) begin
      fails++;
      $display("FAIL jalr_pc: got %0h expected 40", bus.pc);
    end
    bus.PCReg = 8'hFC;
    set_in(I_JALR, 1'b0);
    tick();
    set_in(I_ADDI, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h00) begin
      fails++;
      $display("FAIL pc_wrap: got %0h expected 0", bus.pc);
    end
  endtask

  task automatic test_decode_misc();
    set_in(I_SRAI, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.ALUControl} !== 5'b1_1101
        || bus.IMM !== 8'h02) begin
      fails++;
      $display("FAIL srai_ctrl: got %b imm %0h expected 11101 imm 2",
               {bus.ALUSrc, bus.ALUControl}, bus.IMM);
    end
    tick();
    set_in(I_SUB, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.ALUControl, bus.RegWrite} !== 6'b0_1000_1) begin
      fails++;
      $display("FAIL sub_ctrl: got %b expected 010001",
               {bus.ALUSrc, bus.ALUControl, bus.RegWrite});
    end
    tick();
    set_in(I_LUI, 1'b0);
    tests++;
    if (bus.RS1 !== 5'd0 || bus.RD !== 5'd5 || bus.IMM !== 8'h00
        || {bus.ALUSrc, bus.ALUControl, bus.RegWrite}
           !== 6'b1_0000_1) begin
      fails++;
      $display("FAIL lui_dec: got rs1 %0d rd %0d imm %0h ctl %b expected 0 5 0 100001",
               bus.RS1, bus.RD, bus.IMM,
               {bus.ALUSrc, bus.ALUControl, bus.RegWrite});
    end
    tick();
    set_in(I_UNK, 1'b0);
    tests++;
    if ({bus.ALUSrc, bus.RegWrite, bus.link, bus.MemRead,
         bus.MemWrite} !== 5'b0) begin
      fails++;
      $display("FAIL unknown_strobes: got %b expected 00000",
               {bus.ALUSrc, bus.RegWrite, bus.link,
                bus.MemRead, bus.MemWrite});
    end
    tick();
    tests++;
    if (bus.pc !== 8'h10) begin
      fails++;
      $display("FAIL unknown_pc: got %0h expected 10", bus.pc);
    end
    set_in(I_ADDI, 1'b0);
    tick();
  endtask

  task automatic test_interrupt();
    set_in(I_SW, 1'b1);
    tick();
    bus.interrupt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_in(I_SW, c < 2);
      tests++;
      if (bus.MemWrite !== 1'b1 || bus.MemRead !== 1'b0) begin
        fails++;
        $display("FAIL sw_memwrite: got %b%b expected 10",
                 bus.MemWrite, bus.MemRead);
      end
      if (c == 2) begin
        tests++;
        if ({bus.RegWrite, bus.MemtoReg} !== 2'b00) begin
          fails++;
          $display("FAIL sw_done_wb: got %b expected 00",
                   {bus.RegWrite, bus.MemtoReg});
        end
      end
      tick();
      if (c < 2) begin
        tests++;
        if (bus.pc !== 8'h14) begin
          fails++;
          $display("FAIL sw_wait_pc: got %0h expected 14", bus.pc);
        end
      end
    end
`ifdef CTRL_INTERRUPT_EN
    tests++;
    if (bus.pc !== 8'h10) begin
      fails++;
      $display("FAIL irq_entry_pc: got %0h expected 10", bus.pc);
    end
    set_in(I_CSRR, 1'b0);
    tests++;
    if ({bus.link, bus.RegWrite} !== 2'b11 || bus.pclink !== 8'h18) begin
      fails++;
      $display("FAIL csrr_sepc: got %b/%0h expected 11/18",
               {bus.link, bus.RegWrite}, bus.pclink);
    end
    tick();
    set_in(I_ADDI, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h18) begin
      fails++;
      $display("FAIL irq_masked_pc: got %0h expected 18", bus.pc);
    end
    set_in(I_MRET, 1'b0);
    tests++;
    if ({bus.RegWrite, bus.link} !== 2'b00) begin
      fails++;
      $display("FAIL mret_strobes: got %b expected 00",
               {bus.RegWrite, bus.link});
    end
    tick();
    tests++;
    if (bus.pc !== 8'h18) begin
      fails++;
      $display("FAIL mret_pc: got %0h expected 18", bus.pc);
    end
    set_in(I_ADDI, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h10) begin
      fails++;
      $display("FAIL irq_reenter_pc: got %0h expected 10", bus.pc);
    end
    bus.interrupt = 1'b0;
    set_in(I_CSRR, 1'b0);
    tests++;
    if (bus.pclink !== 8'h1C) begin
      fails++;
      $display("FAIL csrr_sepc2: got %0h expected 1c", bus.pclink);
    end
    tick();
    set_in(I_MRET, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h1C) begin
      fails++;
      $display("FAIL mret2_pc: got %0h expected 1c", bus.pc);
    end
`else
    tests++;
    if (bus.pc !== 8'h18) begin
      fails++;
      $display("FAIL irq_ignored_pc: got %0h expected 18", bus.pc);
    end
    set_in(I_CSRR, 1'b0);
    tests++;
    if ({bus.link, bus.RegWrite} !== 2'b11 || bus.pclink !== 8'h00) begin
      fails++;
      $display("FAIL csrr_zero: got %b/%0h expected 11/0",
               {bus.link, bus.RegWrite}, bus.pclink);
    end
    tick();
    tests++;
    if (bus.pc !== 8'h1C) begin
      fails++;
      $display("FAIL csrr_pc: got %0h expected 1c", bus.pc);
    end
    set_in(I_MRET, 1'b0);
    tick();
    tests++;
    if (bus.pc !== 8'h00) begin
      fails++;
      $display("FAIL mret_zero_pc: got %0h expected 0", bus.pc);
    end
    bus.interrupt = 1'b0;
`endif
  endtask

  task automatic test_reset_mem();
    set_in(I_LW, 1'b1);
    tick();
    set_in(I_LW, 1'b1);
    tests++;
    if (bus.MemRead !== 1'b1) begin
      fails++;
      $display("FAIL rst_mem_pre: got %b expected 1", bus.MemRead);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (bus.pc !== 8'h00) begin
      fails++;
      $display("FAIL rst_mem_pc: got %0h expected 0", bus.pc);
    end
    set_in(I_LW, 1'b1);
    tests++;
    if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin
      fails++;
      $display("FAIL rst_mem_exec: got %b expected 00",
               {bus.MemRead, bus.MemWrite});
    end
    tick();
    tests++;
    if (bus.pc !== 8'h00) begin
      fails++;
      $display("FAIL rst_mem_hold_pc: got %0h expected 0", bus.pc);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_jump();
    test_decode_misc();
    test_interrupt();
    test_reset_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: got no summary expected finish");
    $fatal(1);
  end
endmodule
